// File: rtl/music_pkg.sv
// Shared types and constants for the score sequencer.
//   score_entry_t : one ROM word, {duration in beats, note number}
//   NOTE_REST     : note number that means silence
//   LAST_ADDR     : highest ROM address; playback never wraps past it
//   seq_state_t   : sequencer FSM states
package music_pkg;

    typedef struct packed {
        logic [7:0] dur;
        logic [7:0] note;
    } score_entry_t;

    localparam logic [7:0] NOTE_REST = 8'd0;
    localparam logic [7:0] LAST_ADDR = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PLAY
    } seq_state_t;

endpackage

// File: rtl/beat_timer.sv
// Beat timer for the score sequencer.
// A free-running tick counter marks beat boundaries, and a beat counter
// counts down the beats of the current note. Both are re-armed by load.
// Ports:
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   load       : re-arm; tick counter cleared, beats_left <= dur
//   dur        : note duration in beats, sampled on load
//   beat_end   : last tick of the current beat
//   last_beat  : the current beat is the final beat of the note
//   in_gap     : within the last GAP_TICKS clocks of the final beat
module beat_timer
    import music_pkg::*;
#(
    parameter int unsigned BEAT_TICKS = 12_500_000,
    parameter int unsigned GAP_TICKS  = 1_562_500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] dur,
    output logic       beat_end,
    output logic       last_beat,
    output logic       in_gap
);

    localparam int unsigned       TICK_W    = $clog2(BEAT_TICKS);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BEAT_TICKS - 1);
    localparam logic [TICK_W-1:0] GAP_START = TICK_W'(BEAT_TICKS - GAP_TICKS);
    // With no gap, GAP_START would truncate BEAT_TICKS to a bogus value.
    localparam bit                HAS_GAP   = (GAP_TICKS != 0);

    logic [TICK_W-1:0] tick_q, tick_d;
    logic [7:0]        beats_left_q, beats_left_d;

    assign beat_end  = (tick_q == TICK_LAST);
    assign last_beat = (beats_left_q == 8'd1);
    assign in_gap    = HAS_GAP && last_beat && (tick_q >= GAP_START);

    always_comb begin
        tick_d       = beat_end ? '0 : tick_q + TICK_W'(1);
        beats_left_d = beats_left_q;
        // Hold at zero once drained so an idle timer never wraps round.
        if (beat_end && (beats_left_q != 8'd0)) begin
            beats_left_d = beats_left_q - 8'd1;
        end
        if (load) begin
            tick_d       = '0;
            beats_left_d = dur;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values that existed before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q       <= '0;
            beats_left_q <= 8'd0;
        end else begin
            tick_q       <= tick_d;
            beats_left_q <= beats_left_d;
        end
    end

endmodule

// File: rtl/score_sequencer.sv
// Score sequencer: walks the score ROM from START_ADDR, holds each
// {duration, note} entry for duration x BEAT_TICKS clocks and drops the gate
// for the last GAP_TICKS clocks of every note so repeated notes separate.
// A zero duration is the end marker (also implied after address 255).
// Ports:
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   start    : 1-cycle pulse, begin playback (ignored while busy)
//   stop     : 1-cycle pulse, abort playback (wins over start)
//   loop_en  : restart at START_ADDR instead of finishing at the end marker
//   count    : registered ROM address
//   entry    : combinational ROM data for count, {dur[15:8], note[7:0]}
//   note     : current note, 0 while idle or resting
//   gate     : sound the note
//   busy     : not idle
//   done     : 1-cycle pulse, registered, in the first idle cycle after
//              playback reaches the end marker
module score_sequencer
    import music_pkg::*;
#(
    parameter int unsigned BEAT_TICKS = 12_500_000,
    parameter int unsigned GAP_TICKS  = 1_562_500,
    parameter logic [7:0]  START_ADDR = 8'd14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        loop_en,
    output logic [7:0]  count,
    input  logic [15:0] entry,
    output logic [7:0]  note,
    output logic        gate,
    output logic        busy,
    output logic        done
);

    seq_state_t   state_q, state_d;
    logic [7:0]   count_q, count_d;
    logic [7:0]   note_q, note_d;
    logic         done_q, done_d;
    logic         timer_load;
    logic         beat_end, last_beat, in_gap;
    logic         play_last;
    logic         restart_ok;
    score_entry_t entry_s;

    assign entry_s    = entry;
    assign play_last  = beat_end && last_beat;
    // Looping back while already at START_ADDR would spin forever on an
    // empty score, so that case finishes instead.
    assign restart_ok = loop_en && (count_q != START_ADDR);

    beat_timer #(
        .BEAT_TICKS (BEAT_TICKS),
        .GAP_TICKS  (GAP_TICKS)
    ) u_beat_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (timer_load),
        .dur       (entry_s.dur),
        .beat_end  (beat_end),
        .last_beat (last_beat),
        .in_gap    (in_gap)
    );

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        note_d     = note_q;
        done_d     = 1'b0;
        timer_load = 1'b0;

        if (stop) begin
            state_d = IDLE;
            count_d = START_ADDR;
            note_d  = NOTE_REST;
        end else begin
            case (state_q)
                IDLE: begin
                    count_d = START_ADDR;
                    note_d  = NOTE_REST;
                    if (start) begin
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    if (entry_s.dur == 8'd0) begin
                        if (restart_ok) begin
                            count_d = START_ADDR;
                        end else begin
                            state_d = IDLE;
                            count_d = START_ADDR;
                            note_d  = NOTE_REST;
                            done_d  = 1'b1;
                        end
                    end else begin
                        note_d     = entry_s.note;
                        timer_load = 1'b1;
                        state_d    = PLAY;
                    end
                end
                PLAY: begin
                    if (play_last) begin
                        if (count_q != LAST_ADDR) begin
                            count_d = count_q + 8'd1;
                            state_d = FETCH;
                        end else if (restart_ok) begin
                            count_d = START_ADDR;
                            state_d = FETCH;
                        end else begin
                            state_d = IDLE;
                            count_d = START_ADDR;
                            note_d  = NOTE_REST;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= START_ADDR;
            note_q  <= NOTE_REST;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            note_q  <= note_d;
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign note  = note_q;
    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign gate  = (state_q == PLAY) && (note_q != NOTE_REST) && !in_gap;

endmodule

// File: tb/tb_score_sequencer.sv
// Self-checking bench for score_sequencer with a behavioural ROM.
// The reference model expands each score entry into the list of per-cycle
// outputs it should produce and replays that list against the DUT.
module tb_score_sequencer;

    localparam int unsigned BT = 4;
    localparam int unsigned GT = 1;
    localparam logic [7:0]  SA = 8'd14;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop, loop_en;
    logic [7:0]  count, note;
    logic [15:0] entry;
    logic        gate, busy, done;

    logic [15:0] rom [256];
    assign entry = rom[count];

    always #5 clk = ~clk;

    score_sequencer #(
        .BEAT_TICKS (BT),
        .GAP_TICKS  (GT),
        .START_ADDR (SA)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .loop_en (loop_en),
        .count   (count),
        .entry   (entry),
        .note    (note),
        .gate    (gate),
        .busy    (busy),
        .done    (done)
    );

    typedef struct packed {
        logic [7:0] count;
        logic [7:0] note;
        logic       gate;
        logic       busy;
        logic       done;
    } obs_t;

    obs_t       exp_q[$];
    obs_t       cur_exp;
    bit         playing;
    logic [7:0] cur_addr;
    logic [7:0] last_note;
    int         n_checks = 0;
    int         n_errors = 0;
    int         gate_hi  = 0;
    int         done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic obs_t idle_obs(input bit d);
        obs_t o;
        o.count = SA;
        o.note  = 8'd0;
        o.gate  = 1'b0;
        o.busy  = 1'b0;
        o.done  = d;
        return o;
    endfunction

    function automatic obs_t mk(input logic [7:0] c, input logic [7:0] n, input bit g);
        obs_t o;
        o.count = c;
        o.note  = n;
        o.gate  = g;
        o.busy  = 1'b1;
        o.done  = 1'b0;
        return o;
    endfunction

    // Append the cycles produced by the entry at cur_addr: one fetch cycle,
    // then dur*BT play cycles with the gate low for the last GT of them.
    task automatic expand();
        logic [15:0] e;
        int          n;
        e = rom[cur_addr];
        exp_q.push_back(mk(cur_addr, last_note, 1'b0));
        if (e[15:8] == 8'd0) begin
            if (loop_en && cur_addr != SA) cur_addr = SA;
            else begin
                exp_q.push_back(idle_obs(1'b1));
                playing = 1'b0;
            end
        end else begin
            n = int'(e[15:8]) * int'(BT);
            for (int k = 0; k < n; k++)
                exp_q.push_back(mk(cur_addr, e[7:0], (e[7:0] != 8'd0) && (k < n - int'(GT))));
            last_note = e[7:0];
            if (cur_addr == 8'hFF) begin
                if (loop_en && cur_addr != SA) cur_addr = SA;
                else begin
                    exp_q.push_back(idle_obs(1'b1));
                    playing = 1'b0;
                end
            end else begin
                cur_addr = cur_addr + 8'd1;
            end
        end
    endtask

    // Apply this cycle's inputs to the model and work out the next cycle.
    task automatic advance(input bit s, input bit p);
        if (p) begin
            exp_q.delete();
            playing = 1'b0;
        end else if (s && !cur_exp.busy) begin
            exp_q.delete();
            playing   = 1'b1;
            cur_addr  = SA;
            last_note = 8'd0;
        end
        if (exp_q.size() == 0 && playing) expand();
        if (exp_q.size() != 0) cur_exp = exp_q.pop_front();
        else cur_exp = idle_obs(1'b0);
    endtask

    task automatic cycle(input bit s, input bit p);
        @(negedge clk);
        check("count", count, cur_exp.count);
        check("note", note, cur_exp.note);
        check("gate", gate, cur_exp.gate);
        check("busy", busy, cur_exp.busy);
        check("done", done, cur_exp.done);
        if (gate) gate_hi++;
        if (done) done_cnt++;
        start = s;
        stop  = p;
        advance(s, p);
    endtask

    task automatic run(input int n);
        repeat (n) cycle(1'b0, 1'b0);
    endtask

    task automatic clr();
        gate_hi  = 0;
        done_cnt = 0;
        for (int a = 0; a < 256; a++) rom[a] = 16'h0000;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_count"}, count, SA);
        check({tag, "_note"}, note, 0);
        check({tag, "_gate"}, gate, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic rand_rom();
        logic [7:0] d, n;
        for (int a = 0; a < 256; a++) rom[a] = 16'h0000;
        for (int a = 14; a < 41; a++) begin
            d = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 3));
            n = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 127));
            rom[a] = {d, n};
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        loop_en = 1'b0;
        clr();
        playing = 1'b0;
        cur_exp = idle_obs(1'b0);

        // Reset values, then ten quiet cycles.
        #12;
        check_reset_vals("rst");
        @(negedge clk);
        rst = 1'b0;
        run(10);

        // Single note then end marker.
        clr();
        rom[14] = {8'd2, 8'd55};
        cycle(1'b1, 1'b0);
        run(14);
        check("t2_gate_cycles", gate_hi, 7);
        check("t2_done_pulses", done_cnt, 1);

        // Rest entry.
        clr();
        rom[14] = {8'd2, 8'd0};
        cycle(1'b1, 1'b0);
        run(14);
        check("t3_gate_cycles", gate_hi, 0);
        check("t3_done_pulses", done_cnt, 1);

        // Repeated note keeps a gap between the two soundings.
        clr();
        rom[14] = {8'd1, 8'd53};
        rom[15] = {8'd1, 8'd53};
        cycle(1'b1, 1'b0);
        run(14);
        check("t4_gate_cycles", gate_hi, 6);

        // Stop in the third play cycle, then start+stop together.
        clr();
        rom[14] = {8'd4, 8'd44};
        cycle(1'b1, 1'b0);
        run(3);
        cycle(1'b0, 1'b1);
        run(4);
        cycle(1'b1, 1'b1);
        run(4);
        check("t5_done_pulses", done_cnt, 0);

        // Looping with no done; then stop.
        clr();
        loop_en = 1'b1;
        rom[14] = {8'd1, 8'd60};
        cycle(1'b1, 1'b0);
        run(40);
        check("t6_loop_done", done_cnt, 0);
        check("t6_loop_gate", (gate_hi >= 15) ? 1 : 0, 1);
        cycle(1'b0, 1'b1);
        run(2);

        // Empty score with looping enabled must still finish.
        clr();
        rom[14] = 16'h0000;
        cycle(1'b1, 1'b0);
        run(4);
        check("t6_empty_done", done_cnt, 1);

        // Last address: finish without wrapping, then loop back to START.
        for (int pass = 0; pass < 2; pass++) begin
            clr();
            loop_en = (pass == 1);
            for (int a = 14; a < 255; a++) rom[a] = {8'd1, 8'(a)};
            rom[255] = {8'd1, 8'd62};
            cycle(1'b1, 1'b0);
            run(1260);
            check("t6_end255_done", done_cnt, (pass == 0) ? 1 : 0);
            cycle(1'b0, 1'b1);
            run(2);
        end
        loop_en = 1'b0;

        // Asynchronous reset mid-note.
        clr();
        rom[14] = {8'd4, 8'd44};
        cycle(1'b1, 1'b0);
        run(4);
        #2 rst = 1'b1;
        #1 check_reset_vals("arst");
        @(negedge clk);
        check_reset_vals("arst_hold");
        rst = 1'b0;
        exp_q.delete();
        playing = 1'b0;
        cur_exp = idle_obs(1'b0);
        run(3);

        // Randomised scores and control pulses.
        for (int blk = 0; blk < 4; blk++) begin
            rand_rom();
            for (int c = 0; c < 600; c++) begin
                if (!playing && !cur_exp.busy && $urandom_range(0, 7) == 0)
                    loop_en = $urandom_range(0, 1) == 1;
                cycle($urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0);
            end
            cycle(1'b0, 1'b1);
            run(1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
